// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - multi-cycle accumulator CPU core (HLT SKZ ADD AND XOR LDA STO JMP)
// Optional single-step input enabled by defining CPU_SINGLE_STEP_EN.
module acc_cpu_core #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              halt,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic [2:0]        opcode,
  output logic              fetch,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr
);

  localparam int IR_W = 2 * DATA_W;

  if (IR_W < ADDR_W + 3) begin : g_width_check
    $error("acc_cpu_core: 2*DATA_W must be >= ADDR_W+3");
  end

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    S_IF1  = 3'd0,
    S_IF2  = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [IR_W-1:0]   ir, ir_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic              go;

`ifdef CPU_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign opcode  = ir[IR_W-1 -: 3];
  assign ir_addr = ir[ADDR_W-1:0];
  assign pc_addr = pc;

  // The core only ever drives the bus in the STO memory cycle.
  assign data = wr ? acc : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF1;
      pc    <= RESET_PC;
      ir    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    acc_nxt   = acc;
    rd        = 1'b0;
    wr        = 1'b0;
    fetch     = 1'b0;
    halt      = 1'b0;
    addr      = pc;

    case (state)
      S_IF1: begin
        if (go) begin
          rd                      = 1'b1;
          fetch                   = 1'b1;
          ir_nxt[IR_W-1 -: DATA_W] = data;
          pc_nxt                  = pc + ADDR_W'(1);
          state_nxt               = S_IF2;
        end
      end
      S_IF2: begin
        rd                  = 1'b1;
        fetch               = 1'b1;
        ir_nxt[DATA_W-1:0]  = data;
        pc_nxt              = pc + ADDR_W'(1);
        state_nxt           = S_EX;
      end
      S_EX: begin
        case (opcode)
          OP_HLT: state_nxt = S_HALT;
          OP_SKZ: begin
            if (acc == '0) pc_nxt = pc + ADDR_W'(2);
            state_nxt = S_IF1;
          end
          OP_JMP: begin
            pc_nxt    = ir_addr;
            state_nxt = S_IF1;
          end
          default: state_nxt = S_MEM;
        endcase
      end
      S_MEM: begin
        addr = ir_addr;
        case (opcode)
          OP_LDA: begin rd = 1'b1; acc_nxt = data;       end
          OP_ADD: begin rd = 1'b1; acc_nxt = acc + data; end
          OP_AND: begin rd = 1'b1; acc_nxt = acc & data; end
          OP_XOR: begin rd = 1'b1; acc_nxt = acc ^ data; end
          OP_STO: wr = 1'b1;
          default: ;
        endcase
        state_nxt = S_IF1;
      end
      S_HALT: halt = 1'b1;
      default: state_nxt = S_IF1;
    endcase

    // Strobes follow reset asynchronously so an aborted cycle never reaches memory.
    if (!reset) begin
      rd    = 1'b0;
      wr    = 1'b0;
      fetch = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - randomized self-checking bench for acc_cpu_core against an ISA-level model
`timescale 1ns/1ps
module tb_acc_cpu_core;
  localparam int DW  = 8;
  localparam int AW  = 13;
  localparam int MSZ = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  logic          halt, rd, wr, fetch;
  logic [AW-1:0] addr, ir_addr, pc_addr;
  logic [2:0]    opcode;
  wire  [DW-1:0] data;

  logic [DW-1:0] mem      [MSZ];
  logic [DW-1:0] init_img [MSZ];
  logic [DW-1:0] m_mem    [MSZ];
  logic          load_req = 1'b0;

  logic [AW-1:0] exp_fetch[$];
  int            exp_edges;
  bit            exp_halts;
  int            last_edges;
  logic [AW-1:0] last_if1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign data = (rd && !wr) ? mem[addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (load_req) begin
      for (int a = 0; a < MSZ; a++) mem[a] <= init_img[a];
    end else if (wr) begin
      mem[addr] <= data;
    end
  end

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(13'd0)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef CPU_SINGLE_STEP_EN
    .step    (step),
`endif
    .halt    (halt),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .data    (data),
    .opcode  (opcode),
    .fetch   (fetch),
    .ir_addr (ir_addr),
    .pc_addr (pc_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int a = 0; a < MSZ; a++) init_img[a] = '0;
  endtask

  task automatic emit(inout int pc, input logic [2:0] op, input logic [AW-1:0] a);
    init_img[pc]     = {op, a[12:8]};
    init_img[pc + 1] = a[7:0];
    pc += 2;
  endtask

  // Instruction-level interpreter: fetch order, edge count and final memory image.
  task automatic model_run(input int max_instr);
    logic [AW-1:0] pc, pc1, ia;
    logic [DW-1:0] acc, hi, lo;
    for (int a = 0; a < MSZ; a++) m_mem[a] = init_img[a];
    exp_fetch.delete();
    exp_edges = 0;
    exp_halts = 0;
    pc  = '0;
    acc = '0;
    for (int n = 0; n < max_instr && !exp_halts; n++) begin
      exp_fetch.push_back(pc);
      pc1 = pc + 13'd1;
      hi  = m_mem[pc];
      lo  = m_mem[pc1];
      pc  = pc1 + 13'd1;
      ia  = {hi[4:0], lo};
      case (hi[7:5])
        3'd0: begin exp_halts = 1; exp_edges += 3; end
        3'd1: begin if (acc == 0) pc = pc + 13'd2; exp_edges += 3; end
        3'd7: begin pc = ia; exp_edges += 3; end
        default: begin
          exp_edges += 4;
          case (hi[7:5])
            3'd2: acc = acc + m_mem[ia];
            3'd3: acc = acc & m_mem[ia];
            3'd4: acc = acc ^ m_mem[ia];
            3'd5: acc = m_mem[ia];
            default: m_mem[ia] = acc;
          endcase
        end
      endcase
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_prog(input int budget, input bit want_halt);
    int            edges, fi, diffs;
    bit            prev_fetch;
    logic [AW-1:0] exp_a;
    edges = 0; fi = 0; prev_fetch = 0;
    apply_reset();
    forever begin
      check("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
      if (fetch && !prev_fetch) begin
        if (fi < exp_fetch.size()) check("if1_addr", addr, exp_fetch[fi]);
        else check("extra_fetch", fi, exp_fetch.size());
        last_if1 = addr;
        fi++;
      end else if (fetch) begin
        if (fi >= 1 && fi <= exp_fetch.size()) begin
          exp_a = exp_fetch[fi-1] + 13'd1;
          check("if2_addr", addr, exp_a);
        end
      end
      prev_fetch = fetch;
      if (halt || edges >= budget) break;
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
    end
    last_edges = edges;
    check("halt_state", halt, want_halt);
    if (want_halt) check("halt_edges", edges, exp_edges);
    check("fetch_count", fi, exp_fetch.size());
    diffs = 0;
    for (int a = 0; a < MSZ; a++) if (mem[a] !== m_mem[a]) diffs++;
    check("mem_image", diffs, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pc, kind;
    logic [AW-1:0] tgt;

    // Reset values with reset held low
    clear_img();
    repeat (3) @(negedge clk);
    #1;
    check("rst_halt", halt, 0);
    check("rst_rd", rd, 0);
    check("rst_wr", wr, 0);
    check("rst_fetch", fetch, 0);
    check("rst_addr", addr, 0);
    check("rst_opcode", opcode, 0);
    check("rst_ir_addr", ir_addr, 0);
    check("rst_pc_addr", pc_addr, 0);

    // Program A: LDA 10; ADD 11; STO 12; HLT
    clear_img();
    pc = 0;
    emit(pc, 3'd5, 13'h10);
    emit(pc, 3'd2, 13'h11);
    emit(pc, 3'd6, 13'h12);
    emit(pc, 3'd0, 13'h0);
    init_img[13'h10] = 8'h05;
    init_img[13'h11] = 8'h07;
    model_run(100);
    run_prog(exp_edges + 20, 1'b1);
    check("progA_mem12", mem[13'h12], 8'h0C);
    check("progA_halt_edge", last_edges, 15);

    // SKZ with acc=0 skips one instruction
    clear_img();
    pc = 0;
    emit(pc, 3'd7, 13'h20);
    init_img[13'h20] = 8'h20;
    model_run(100);
    run_prog(exp_edges + 20, 1'b1);
    check("skz0_next", last_if1, 13'h24);

    // SKZ with acc=1 falls through
    clear_img();
    pc = 0;
    emit(pc, 3'd5, 13'h40);
    emit(pc, 3'd7, 13'h20);
    init_img[13'h40] = 8'h01;
    init_img[13'h20] = 8'h20;
    model_run(100);
    run_prog(exp_edges + 20, 1'b1);
    check("skz1_next", last_if1, 13'h22);

    // JMP to the top of memory; second fetch word wraps to 0x0000
    clear_img();
    init_img[0] = 8'hFF;
    init_img[1] = 8'hFF;
    init_img[MSZ-1] = 8'hFF;
    model_run(3);
    run_prog(exp_edges - 1, 1'b0);

    // Logic ops and ADD carry discard
    clear_img();
    pc = 0;
    emit(pc, 3'd5, 13'h30);
    emit(pc, 3'd4, 13'h31);
    emit(pc, 3'd6, 13'h40);
    emit(pc, 3'd3, 13'h32);
    emit(pc, 3'd6, 13'h41);
    emit(pc, 3'd2, 13'h33);
    emit(pc, 3'd6, 13'h42);
    emit(pc, 3'd0, 13'h0);
    init_img[13'h30] = 8'hF0;
    init_img[13'h31] = 8'hFF;
    init_img[13'h32] = 8'h3C;
    init_img[13'h33] = 8'hF5;
    model_run(100);
    run_prog(exp_edges + 20, 1'b1);
    check("xor_result", mem[13'h40], 8'h0F);
    check("and_result", mem[13'h41], 8'h0C);
    check("add_result", mem[13'h42], 8'h01);

    // Reset asserted in the STO memory cycle
    clear_img();
    pc = 0;
    emit(pc, 3'd5, 13'h30);
    emit(pc, 3'd6, 13'h50);
    init_img[13'h30] = 8'h5A;
    init_img[13'h50] = 8'h11;
    apply_reset();
    for (int i = 0; i < 20 && !wr; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    check("sto_wr_seen", wr, 1);
    check("sto_data_drive", data, 8'h5A);
    reset = 1'b0;
    #1;
    check("abort_wr", wr, 0);
    check("abort_rd", rd, 0);
    check("abort_pc", pc_addr, 0);
    check("abort_addr", addr, 0);
    check("abort_ir_addr", ir_addr, 0);
    @(posedge clk);
    #1;
    check("abort_mem_kept", mem[13'h50], 8'h11);
    reset = 1'b1;

    // Random straight-line programs with forward jumps
    for (int r = 0; r < 8; r++) begin
      clear_img();
      pc = 0;
      for (int i = 0; i < 10; i++) begin
        kind = $urandom_range(0, 6);
        tgt  = 13'h100 + 13'($urandom_range(0, 15));
        case (kind)
          0: emit(pc, 3'd1, 13'h0);
          1: emit(pc, 3'd2, tgt);
          2: emit(pc, 3'd3, tgt);
          3: emit(pc, 3'd4, tgt);
          4: emit(pc, 3'd5, tgt);
          5: emit(pc, 3'd6, tgt);
          default: emit(pc, 3'd7, 13'(2 * (i + 1 + $urandom_range(0, 2))));
        endcase
      end
      emit(pc, 3'd6, 13'h1F0);
      emit(pc, 3'd0, 13'h0);
      for (int k = 0; k < 16; k++)
        init_img[13'h100 + k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      model_run(100);
      run_prog(exp_edges + 20, exp_halts);
    end

`ifdef CPU_SINGLE_STEP_EN
    begin
      int rd_cnt, fetch_cnt, ld_cnt;
      clear_img();
      pc = 0;
      emit(pc, 3'd5, 13'h30);
      emit(pc, 3'd5, 13'h31);
      init_img[13'h30] = 8'h12;
      init_img[13'h31] = 8'h34;
      step = 1'b0;
      apply_reset();
      rd_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (rd) rd_cnt++;
        @(posedge clk);
        @(negedge clk);
        #1;
      end
      check("step_idle_rd", rd_cnt, 0);
      check("step_idle_pc", pc_addr, 0);
      step = 1'b1;
      @(posedge clk);
      @(negedge clk);
      step = 1'b0;
      #1;
      rd_cnt = 0; fetch_cnt = 0; ld_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (rd) rd_cnt++;
        if (fetch) fetch_cnt++;
        if (rd && !fetch && addr == 13'h30) ld_cnt++;
        @(posedge clk);
        @(negedge clk);
        #1;
      end
      check("step_rd_count", rd_cnt, 2);
      check("step_fetch_count", fetch_cnt, 1);
      check("step_lda_count", ld_cnt, 1);
      check("step_pc", pc_addr, 2);
      step = 1'b1;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
